// File: rtl/traffic_pkg.sv
// Shared types, per-row constants and helpers for the traffic lane field.
package traffic_pkg;

  // Spawn state of one lane: emitting dark gap cells or lit car cells.
  typedef enum logic {GAP, CAR} lane_state_t;

  // Ticks between shifts for each row (1 + row % 3); rows 0 and 15 are unused.
  localparam int unsigned LANE_PERIOD [16] = '{1, 2, 3, 1, 2, 3, 1, 2, 3, 1, 2, 3, 1, 2, 3, 1};

  // 1 = cars move toward increasing y (odd rows), 0 = toward decreasing y.
  localparam bit LANE_DIR [16] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

  // Galois feedback mask applied when the bit shifted out is 1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Car length from two random bits: 1, 2, 3 or 2 cells.
  function automatic logic [1:0] car_len(input logic [1:0] r);
    unique case (r)
      2'b00:   car_len = 2'd1;
      2'b01:   car_len = 2'd2;
      2'b10:   car_len = 2'd3;
      default: car_len = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/traffic_lane.sv
// One traffic row: period counter, gap/car spawn machine and 16-cell shift register.
module traffic_lane
  import traffic_pkg::*;
#(
  parameter int unsigned Period  = 1,
  parameter bit          ShiftUp = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tick_i,
  input  logic [1:0]  r_i,
  output logic [15:0] row_o
);

  localparam logic [1:0] Reload = 2'(Period - 1);

  logic [1:0]  per_q, per_d;
  lane_state_t state_q, state_d;
  logic [2:0]  rem_q, rem_d, rem_dec;
  logic [15:0] row_q, row_d;
  logic        spawn;

  // Next state: count ticks down; on expiry shift in one cell chosen by the spawn machine.
  always_comb begin
    per_d   = per_q;
    state_d = state_q;
    rem_d   = rem_q;
    row_d   = row_q;
    spawn   = 1'b0;
    rem_dec = rem_q - 3'd1;
    if (tick_i) begin
      if (per_q == 2'd0) begin
        per_d = Reload;
        unique case (state_q)
          GAP: begin
            spawn = 1'b0;
            if (rem_dec == 3'd0) begin
              state_d = CAR;
              rem_d   = {1'b0, car_len(r_i)};
            end else begin
              rem_d = rem_dec;
            end
          end
          CAR: begin
            spawn = 1'b1;
            if (rem_dec == 3'd0) begin
              state_d = GAP;
              rem_d   = 3'd2 + {1'b0, r_i};
            end else begin
              rem_d = rem_dec;
            end
          end
          default: ;
        endcase
        row_d = ShiftUp ? {row_q[14:0], spawn} : {spawn, row_q[15:1]};
      end else begin
        per_d = per_q - 2'd1;
      end
    end
  end

  // State registers with synchronous reset to an empty lane about to emit a 2-cell gap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      per_q   <= Reload;
      state_q <= GAP;
      rem_q   <= 3'd2;
      row_q   <= '0;
    end else begin
      per_q   <= per_d;
      state_q <= state_d;
      rem_q   <= rem_d;
      row_q   <= row_d;
    end
  end

  assign row_o = row_q;

endmodule

// File: rtl/traffic_lanes.sv
// Scrolling red-car plane for the 16x16 matrix: tick divider, shared LFSR and
// lanes 1..14; rows 0 and 15 are always dark.
// Optional macro TRAFFIC_SPEEDUP_EN: each win pulse halves the tick period (up to 3 times).
module traffic_lanes
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 25_000_000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               win,
  output logic [15:0][15:0]  RedPixels
);

  localparam logic [31:0] TickDiv = 32'(TICK_DIV);

  logic [31:0] cnt_q, cnt_d, div_eff, wrap_at;
  logic [15:0] lfsr_q, lfsr_d;
  logic        tick;

`ifdef TRAFFIC_SPEEDUP_EN
  logic [1:0]  level_q, level_d;
  logic [31:0] div_shift;

  // Speed level saturates at 3; the divider never drops below one cycle per tick.
  always_comb begin
    div_shift = TickDiv >> level_q;
    div_eff   = (div_shift == '0) ? 32'd1 : div_shift;
    level_d   = level_q;
    if (enable && win && (level_q != 2'd3)) level_d = level_q + 2'd1;
  end

  // Speed level register.
  always_ff @(posedge clock) begin
    if (reset) level_q <= '0;
    else       level_q <= level_d;
  end
`else
  logic unused_win;
  assign unused_win = win;
  assign div_eff    = TickDiv;
`endif

  // Tick divider and LFSR advance; both freeze while enable is low.
  // A count already past a freshly lowered threshold wraps without a tick.
  always_comb begin
    wrap_at = div_eff - 32'd1;
    tick    = enable & (cnt_q == wrap_at);
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    if (enable) begin
      cnt_d  = (cnt_q >= wrap_at) ? '0 : cnt_q + 32'd1;
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  // Divider and LFSR registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      lfsr_q <= LFSR_SEED;
    end else begin
      cnt_q  <= cnt_d;
      lfsr_q <= lfsr_d;
    end
  end

  logic [15:0] lane_row [1:14];

  // Lane x draws its random bits from LFSR bits x+1 and x (x+1 never wraps for x <= 14).
  for (genvar x = 1; x <= 14; x++) begin : g_lane
    traffic_lane #(
      .Period  (LANE_PERIOD[x]),
      .ShiftUp (LANE_DIR[x])
    ) u_lane (
      .clk_i  (clock),
      .rst_i  (reset),
      .tick_i (tick),
      .r_i    ({lfsr_q[x+1], lfsr_q[x]}),
      .row_o  (lane_row[x])
    );
  end

  // Assemble the plane; the safe rows stay hard-wired dark.
  always_comb begin
    RedPixels = '0;
    for (int x = 1; x <= 14; x++) RedPixels[x] = lane_row[x];
  end

endmodule
